// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch block.
//   fetch_state_t : fetch sequencer states (REQ, VALID, DRAIN, HALT)
//   PC_INC        : word-address increment applied to the PC
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    VALID = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] PC_INC = 32'd1;

endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: bundles the instruction-memory handshake, the decode-side
// buffer outputs and the execute-side redirect for fetch_ctrl.
//   imem_req/imem_addr   fetch -> memory request, word address
//   imem_ack/imem_rdata  memory -> fetch completion and instruction word
//   if_valid/if_inst/if_pc  fetch -> decode buffered instruction
//   if_ready             decode -> fetch consume
//   br_taken/br_target   execute -> fetch redirect
//   halted               fetch stopped on halt encoding
// Modports: master = fetch_ctrl side, slave = environment side.
interface fetch_ctrl_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        if_ready;
  logic        br_taken;
  logic [31:0] br_target;
  logic        halted;

  modport master (
    output imem_req, imem_addr, if_valid, if_inst, if_pc, halted,
    input  imem_ack, imem_rdata, if_ready, br_taken, br_target
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_inst, if_pc, halted,
    output imem_ack, imem_rdata, if_ready, br_taken, br_target
  );

endinterface

// File: rtl/pc_add4.sv
// pc_add4: PC incrementer. The name is historical; the PC is word-addressed
// so the step is PC_INC (1), wrapping modulo 2^32.
//   pc      in  32  current PC
//   pc_next out 32  pc + PC_INC
module pc_add4
  import fetch_pkg::*;
(
  input  logic [31:0] pc,
  output logic [31:0] pc_next
);

  assign pc_next = pc + PC_INC;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch sequencer. Owns the architectural PC, issues
// word-addressed requests over a req/ack handshake, buffers one instruction
// for decode and applies branch redirects, squashing wrong-path fetches
// (including one already in flight, which is drained and discarded).
// Ports:
//   clk    in  clock, all state on rising edge
//   reset  in  synchronous active-high reset
//   bus    fetch_ctrl_if.master (memory, decode and redirect signals)
// Parameters: RESET_PC (PC after reset), HALT_INST (halt encoding).
// Optional feature: define FETCH_HALT_EN to stop fetch after consuming
// HALT_INST; without it halted is constant 0 and HALT_INST is ordinary.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_INST = 32'hFFFF_FFFF
) (
  input  logic          clk,
  input  logic          reset,
  fetch_ctrl_if.master  bus
);

`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  ipc_q, ipc_d;
  logic [31:0]  pc_inc;

  pc_add4 u_pc_add4 (
    .pc      (pc_q),
    .pc_next (pc_inc)
  );

  // imem_addr is only reloaded on entry to REQ, so it stays on the old
  // address for the whole of a DRAIN even though pc already moved.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    inst_d  = inst_q;
    ipc_d   = ipc_q;
    case (state_q)
      REQ: begin
        if (bus.br_taken) begin
          pc_d = bus.br_target;
          if (bus.imem_ack) addr_d  = bus.br_target;
          else              state_d = DRAIN;
        end else if (bus.imem_ack) begin
          inst_d  = bus.imem_rdata;
          ipc_d   = pc_q;
          pc_d    = pc_inc;
          state_d = VALID;
        end
      end
      VALID: begin
        if (bus.br_taken) begin
          pc_d    = bus.br_target;
          addr_d  = bus.br_target;
          state_d = REQ;
        end else if (bus.if_ready) begin
          if (HALT_EN && (inst_q == HALT_INST)) begin
            state_d = HALT;
          end else begin
            addr_d  = pc_q;
            state_d = REQ;
          end
        end
      end
      DRAIN: begin
        if (bus.br_taken) pc_d = bus.br_target;
        if (bus.imem_ack) begin
          addr_d  = bus.br_taken ? bus.br_target : pc_q;
          state_d = REQ;
        end
      end
`ifdef FETCH_HALT_EN
      HALT: begin
        if (bus.br_taken) begin
          pc_d    = bus.br_target;
          addr_d  = bus.br_target;
          state_d = REQ;
        end
      end
`endif
      default: state_d = REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= REQ;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      inst_q  <= '0;
      ipc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      inst_q  <= inst_d;
      ipc_q   <= ipc_d;
    end
  end

  // Outputs are gated by reset so the interface is quiet while it is held;
  // the first request then appears in the first cycle after release.
  assign bus.imem_req  = ~reset & ((state_q == REQ) | (state_q == DRAIN));
  assign bus.imem_addr = addr_q;
  // A redirect in VALID squashes the buffer in the same cycle.
  assign bus.if_valid  = ~reset & (state_q == VALID) & ~bus.br_taken;
  assign bus.if_inst   = inst_q;
  assign bus.if_pc     = ipc_q;
`ifdef FETCH_HALT_EN
  assign bus.halted    = ~reset & (state_q == HALT);
`else
  assign bus.halted    = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: self-checking bench for fetch_ctrl. Two instances: u_a with
// default RESET_PC and u_b with RESET_PC = 32'hFFFF_FFFF. Directed steps
// followed by a randomized phase checked against a fetch-stream model.
// Define FETCH_HALT_EN for both RTL and bench to exercise the halt feature.
module tb_fetch_ctrl;

  localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;

  logic clk;
  logic rst_a;
  logic reset_b;
  logic b_ack_en;

  fetch_ctrl_if a_if ();
  fetch_ctrl_if b_if ();

  fetch_ctrl u_a (.clk(clk), .reset(rst_a), .bus(a_if));
  fetch_ctrl #(.RESET_PC(32'hFFFF_FFFF)) u_b (.clk(clk), .reset(reset_b), .bus(b_if));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'd2) return HALT_W;
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  // Instance B: zero-wait memory gated by b_ack_en, decode always ready.
  assign b_if.imem_ack   = b_if.imem_req & b_ack_en;
  assign b_if.imem_rdata = memf(b_if.imem_addr);
  assign b_if.if_ready   = 1'b1;
  assign b_if.br_taken   = 1'b0;
  assign b_if.br_target  = '0;

  int n_assert = 0;
  int n_fail   = 0;

  // Model state: next instruction decode should see, next fresh request
  // address, and whether the outstanding request is a wrong-path one.
  logic [31:0] exp_pc, fetch_ptr, hold_addr, last_pc;
  bit          pending, drain;
  int          wait_cnt, cur_lat, lat_force, n_consumed;

  logic        s_req, s_ack, s_valid, s_halted;
  logic [31:0] s_addr, s_inst, s_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input bit rst, input bit rdy, input bit br, input logic [31:0] tgt);
    @(negedge clk);
    rst_a          = rst;
    a_if.if_ready  = rdy;
    a_if.br_taken  = br;
    a_if.br_target = tgt;
    #1;
    if (!rst && a_if.imem_req) begin
      if (!pending) begin
        cur_lat  = (lat_force >= 0) ? lat_force : int'($urandom_range(0, 3));
        wait_cnt = 0;
      end
      a_if.imem_ack   = (wait_cnt >= cur_lat);
      a_if.imem_rdata = a_if.imem_ack ? memf(a_if.imem_addr) : 32'hDEAD_BEEF;
    end else begin
      a_if.imem_ack   = 1'b0;
      a_if.imem_rdata = 32'hDEAD_BEEF;
    end
    #1;
    s_req = a_if.imem_req;   s_ack = a_if.imem_ack;  s_addr = a_if.imem_addr;
    s_valid = a_if.if_valid; s_inst = a_if.if_inst;  s_pc = a_if.if_pc;
    s_halted = a_if.halted;
    if (rst) begin
      chk("rst_req", s_req, 0);
      chk("rst_valid", s_valid, 0);
      pending = 0; drain = 0; fetch_ptr = '0; exp_pc = '0;
    end else begin
`ifndef FETCH_HALT_EN
      chk("halted_zero", s_halted, 0);
`endif
      if (br) chk("br_mask_valid", s_valid, 0);
      if (s_valid && rdy && !br) begin
        chk("cons_pc", s_pc, exp_pc);
        chk("cons_inst", s_inst, memf(exp_pc));
        last_pc = s_pc;
        exp_pc  = exp_pc + 1;
        n_consumed++;
      end
      if (pending) chk("req_held", s_req, 1);
      if (s_req) begin
        if (!pending) begin
          chk("fresh_addr", s_addr, fetch_ptr);
          hold_addr = s_addr;
        end else begin
          chk("addr_stable", s_addr, hold_addr);
        end
        if (s_ack) begin
          if (!drain) fetch_ptr = fetch_ptr + 1;
          drain = 0; pending = 0;
        end else begin
          pending = 1;
          if (br) drain = 1;
          wait_cnt++;
        end
      end else begin
        pending = 0;
      end
      if (br) begin
        fetch_ptr = tgt;
        exp_pc    = tgt;
      end
    end
  endtask

  task automatic do_reset();
    tick(1, 0, 0, '0);
    tick(1, 0, 0, '0);
    chk("rv_addr", s_addr, 32'h0);
    chk("rv_inst", s_inst, 32'h0);
    chk("rv_pc", s_pc, 32'h0);
    chk("rv_halted", s_halted, 0);
  endtask

  task automatic tickb(input bit r, input bit en);
    @(negedge clk);
    reset_b  = r;
    b_ack_en = en;
    #2;
  endtask

  initial begin
    int c0;
    rst_a = 1; reset_b = 1; b_ack_en = 0;
    a_if.imem_ack = 0; a_if.imem_rdata = '0; a_if.if_ready = 0;
    a_if.br_taken = 0; a_if.br_target = '0;
    pending = 0; drain = 0; wait_cnt = 0; cur_lat = 0; n_consumed = 0;
    exp_pc = '0; fetch_ptr = '0; hold_addr = '0; last_pc = '0;

    // Zero-wait memory, decode always ready: 0,1,2 at one per two cycles.
    lat_force = 0;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      tick(0, 1, 0, '0);
      chk("p1_valid", s_valid, 32'(k % 2));
      if (k % 2 == 0) chk("p1_addr", s_addr, 32'(k / 2));
    end
    chk("p1_count", n_consumed, 3);
`ifdef FETCH_HALT_EN
    for (int k = 0; k < 3; k++) begin
      tick(0, 1, 0, '0);
      chk("halt_flag", s_halted, 1);
      chk("halt_noreq", s_req, 0);
      chk("halt_novalid", s_valid, 0);
    end
    tick(0, 1, 1, 32'h8);
    tick(0, 1, 0, '0);
    chk("halt_exit_flag", s_halted, 0);
    chk("halt_exit_req", s_req, 1);
    chk("halt_exit_addr", s_addr, 32'h8);
`else
    tick(0, 1, 0, '0);
    chk("nohalt_req", s_req, 1);
    chk("nohalt_addr", s_addr, 32'h3);
`endif

    // 3-cycle ack latency, decode stalled for 4 cycles.
    lat_force = 3;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      tick(0, 0, 0, '0);
      chk("p2_addr", s_addr, 32'h0);
      chk("p2_ack", s_ack, 32'(k == 3));
    end
    for (int k = 0; k < 4; k++) begin
      tick(0, 0, 0, '0);
      chk("p2_hold_valid", s_valid, 1);
      chk("p2_hold_inst", s_inst, memf(32'h0));
      chk("p2_hold_pc", s_pc, 32'h0);
      chk("p2_hold_noreq", s_req, 0);
    end
    tick(0, 1, 0, '0);
    tick(0, 1, 0, '0);
    chk("p2_next_req", s_req, 1);
    chk("p2_next_addr", s_addr, 32'h1);

    // Redirect while a request is outstanding: drain old address.
    lat_force = 2;
    do_reset();
    tick(0, 1, 1, 32'h40);
    chk("p3_old_addr", s_addr, 32'h0);
    tick(0, 1, 0, '0);
    chk("p3_drain_addr", s_addr, 32'h0);
    tick(0, 1, 0, '0);
    chk("p3_drain_ack", s_ack, 1);
    chk("p3_drain_ack_addr", s_addr, 32'h0);
    tick(0, 1, 0, '0);
    chk("p3_new_addr", s_addr, 32'h40);
    c0 = n_consumed;
    for (int k = 0; k < 3; k++) tick(0, 1, 0, '0);
    chk("p3_consumed", n_consumed - c0, 1);
    chk("p3_consumed_pc", last_pc, 32'h40);

    // Redirect in VALID with decode ready in the same cycle.
    lat_force = 0;
    do_reset();
    tick(0, 1, 0, '0);
    c0 = n_consumed;
    tick(0, 1, 1, 32'h100);
    chk("p4_masked", s_valid, 0);
    chk("p4_no_consume", n_consumed - c0, 0);
    tick(0, 1, 0, '0);
    chk("p4_req", s_req, 1);
    chk("p4_addr", s_addr, 32'h100);

    // Instance B: RESET_PC wraps, and reset during a wait restarts.
    rst_a = 1; a_if.imem_ack = 0; a_if.br_taken = 0;
    tickb(1, 1);
    chk("b_rst_req", b_if.imem_req, 0);
    chk("b_rst_addr", b_if.imem_addr, 32'hFFFF_FFFF);
    tickb(0, 1);
    chk("b_req0", b_if.imem_req, 1);
    chk("b_addr0", b_if.imem_addr, 32'hFFFF_FFFF);
    tickb(0, 1);
    chk("b_valid0", b_if.if_valid, 1);
    chk("b_pc0", b_if.if_pc, 32'hFFFF_FFFF);
    chk("b_inst0", b_if.if_inst, memf(32'hFFFF_FFFF));
    tickb(0, 1);
    chk("b_addr1", b_if.imem_addr, 32'h0);
    tickb(0, 1);
    chk("b_pc1", b_if.if_pc, 32'h0);
    chk("b_inst1", b_if.if_inst, memf(32'h0));
    tickb(0, 0);
    chk("b_wait_addr", b_if.imem_addr, 32'h1);
    tickb(0, 0);
    chk("b_wait_req", b_if.imem_req, 1);
    tickb(1, 0);
    chk("b_mid_rst_req", b_if.imem_req, 0);
    tickb(1, 0);
    chk("b_mid_rst_addr", b_if.imem_addr, 32'hFFFF_FFFF);
    chk("b_mid_rst_valid", b_if.if_valid, 0);
    tickb(0, 1);
    chk("b_restart_req", b_if.imem_req, 1);
    chk("b_restart_addr", b_if.imem_addr, 32'hFFFF_FFFF);
    tickb(1, 0);

    // Randomized traffic against the fetch-stream model.
    lat_force = -1;
    do_reset();
    c0 = n_consumed;
    for (int k = 0; k < 600; k++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 1) == 0) ? $urandom : 32'hFFFF_FFFE;
      tick($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 11) == 0, tgt);
    end
    chk("rand_progress", 32'(n_consumed > c0 + 20), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences instruction fetch for the core: owns the architectural PC, issues word-addressed requests to instruction memory over a req/ack handshake, and buffers one fetched instruction for decode.
- Applies branch redirects from execute and squashes any wrong-path fetch, including one already in flight.
- Sits between the PC/branch datapath and the decode stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- HALT_INST, 32'hFFFF_FFFF, encoding that stops fetch (only used with FETCH_HALT_EN).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request, held until imem_ack.
- imem_addr  out  32  word address of the outstanding request, stable while imem_req=1.
- imem_ack  in  1  memory completes the request; imem_rdata is valid this cycle.
- imem_rdata  in  32  instruction word.
- if_valid  out  1  buffered instruction available to decode.
- if_inst  out  32  buffered instruction.
- if_pc  out  32  address of if_inst.
- if_ready  in  1  decode consumes when if_valid & if_ready.
- br_taken  in  1  resolved taken branch, one-cycle pulse.
- br_target  in  32  redirect address, valid with br_taken.
- halted  out  1  fetch stopped on HALT_INST; tied 0 without FETCH_HALT_EN.

Behaviour:
- Clock/reset: one clock (clk); reset is synchronous and active-high.
- Reset values: state=REQ, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_inst=0, if_pc=0, halted=0.
- The first request (imem_addr=RESET_PC) is asserted in the first cycle after reset deasserts. Reset mid-transaction abandons it without draining.
- PC arithmetic: word-addressed, next = pc + 1, modulo 2^32 (32'hFFFF_FFFF wraps to 0).
- States:
  - REQ: imem_req=1, imem_addr=pc.
    - On imem_ack: if_inst<=imem_rdata, if_pc<=pc, pc<=pc+1, go VALID.
    - Ack can arrive in the same cycle the request is first asserted (zero-wait memory).
  - VALID: if_valid=1 and imem_req=0.
    - On if_valid & if_ready, go REQ.
    - Throughput is 1 instruction per 2 cycles with zero-wait memory and decode always ready.
  - DRAIN: imem_req=1 with the old imem_addr until imem_ack. The returned data is discarded, then go REQ using the updated pc.
  - HALT: exists only with FETCH_HALT_EN.
- Redirect, priority reset > br_taken > handshake:
  - REQ with imem_ack in the same cycle: data discarded, pc<=br_target, stay REQ.
  - REQ without imem_ack: pc<=br_target, go DRAIN. imem_addr keeps the old address until ack.
  - VALID: buffer dropped, pc<=br_target, go REQ. if_valid is masked combinationally (if_valid = VALID & ~br_taken), so decode never consumes a squashed instruction.
  - DRAIN: pc<=newest br_target, remain DRAIN.
- imem_addr is a register loaded on entry to REQ. It never changes while imem_req=1 and ack has not arrived.

Optional Feature:
- Macro: FETCH_HALT_EN.
- With the macro:
  - When a VALID instruction equal to HALT_INST is consumed, go HALT: halted=1, imem_req=0, if_valid=0.
  - The only exits are reset, or br_taken, which gives pc<=br_target and go REQ with halted cleared.
  - A redirect in the same cycle as consuming HALT_INST wins; HALT is not entered.
- Without the macro: HALT_INST is treated as an ordinary instruction, the HALT state is absent, and halted is constant 0.

Decomposition:
- Shared package fetch_pkg: fetch_state_t enum (REQ, VALID, DRAIN, HALT) and the PC_INC=1 constant.
- The +1 increment uses the existing pc_add4 incrementer as the single sub-module instance.
- Everything else is inline in fetch_ctrl.

Test Plan:
- Reset then zero-wait memory, if_ready=1: requests at addresses 0,1,2. if_inst/if_pc pairs match memory contents at 0,1,2; if_valid is high every second cycle.
- Memory with 3-cycle ack latency, if_ready held 0 for 4 cycles: imem_addr is stable through the wait. if_inst is held and pc is not advanced until if_ready=1.
- br_taken with br_target=32'h40 while in REQ and ack 2 cycles later: DRAIN keeps imem_addr at the old address. That data is never presented; the next request is 32'h40.
- br_taken with br_target=32'h100 in VALID, with if_ready=1 in the same cycle: if_valid=0 that cycle and the next fetch is 32'h100.
- RESET_PC=32'hFFFF_FFFF: first fetch is at FFFF_FFFF and the second at 0. A reset asserted during a wait restarts at RESET_PC.
- FETCH_HALT_EN, memory word 2 = HALT_INST: halted=1 after word 2 is consumed and no further imem_req. br_taken to 32'h8 clears halted and fetches 32'h8.
